// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU_Control codes,
// controller state numbers and datapath mux selects.
package multicycle_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_ORI   = 4'b0001;
    localparam logic [3:0] ALU_LUI   = 4'b0010;
    localparam logic [3:0] ALU_ANDI  = 4'b0011;
    localparam logic [3:0] ALU_LW    = 4'b0100;
    localparam logic [3:0] ALU_SW    = 4'b0101;
    localparam logic [3:0] ALU_BEQ   = 4'b0110;
    localparam logic [3:0] ALU_BNE   = 4'b0111;
    localparam logic [3:0] ALU_J     = 4'b1000;
    localparam logic [3:0] ALU_JAL   = 4'b1001;
    localparam logic [3:0] ALU_RTYPE = 4'b1111;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_EXEC_I    = 4'd3;
    localparam logic [3:0] S_ALU_WB    = 4'd4;
    localparam logic [3:0] S_MEM_ADDR  = 4'd5;
    localparam logic [3:0] S_MEM_READ  = 4'd6;
    localparam logic [3:0] S_MEM_WB    = 4'd7;
    localparam logic [3:0] S_MEM_WRITE = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_JAL_LINK  = 4'd11;
    localparam logic [3:0] S_JR        = 4'd12;
    localparam logic [3:0] S_TRAP      = 4'd13;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_RS = 1'b1;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_JAL,
        CLS_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       error;
    } ctrl_t;

    function automatic op_class_e classify(input logic [5:0] op);
        case (op)
            OP_RTYPE:                        return CLS_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return CLS_IMM;
            OP_LW:                           return CLS_LOAD;
            OP_SW:                           return CLS_STORE;
            OP_BEQ, OP_BNE:                  return CLS_BRANCH;
            OP_J:                            return CLS_JUMP;
            OP_JAL:                          return CLS_JAL;
            default:                         return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALU_ORI;
            OP_LUI:  return ALU_LUI;
            OP_ANDI: return ALU_ANDI;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts consecutive cycles a memory access has been stalled and flags the cycle on which
// the stall reaches MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // Any cycle not spent waiting zeroes the count, so every memory state is entered at 0.
    always_comb begin
        cnt_d = '0;
        if (waiting_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = waiting_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller: fetch/decode/execute/memory/writeback with a
// req/ready memory handshake, stall timeout and sticky trap on illegal opcode or timeout.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic       jump_register_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic [1:0] pc_source_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [3:0] alu_op_o,
    output logic [3:0] state_o,
    output logic       error_o
);

    logic [3:0] state_q, state_d;
    logic       waiting;
    logic       timed_out;
    op_class_e  op_class;
    ctrl_t      ctrl;

    // The branch decision itself is made in the datapath from pc_write_cond/branch_ne.
    logic unused_zero;
    assign unused_zero = zero_i;

    assign op_class = classify(opcode_i);
    assign waiting  = is_mem_state(state_q) && !mem_ready_i;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .waiting_i(waiting),
        .expired_o(timed_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i)    state_d = S_DECODE;
                else if (timed_out) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (op_class)
                    CLS_R:              state_d = jump_register_i ? S_JR : S_EXEC_R;
                    CLS_IMM:            state_d = S_EXEC_I;
                    CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
                    CLS_BRANCH:         state_d = S_BRANCH;
                    CLS_JUMP:           state_d = S_JUMP;
                    CLS_JAL:            state_d = S_JAL_LINK;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR:         state_d = (op_class == CLS_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (mem_ready_i)    state_d = S_MEM_WB;
                else if (timed_out) state_d = S_TRAP;
            end
            S_MEM_WRITE: begin
                if (mem_ready_i)    state_d = S_FETCH;
                else if (timed_out) state_d = S_TRAP;
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL_LINK, S_JR: state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready_i;
                ctrl.pc_write  = mem_ready_i;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_IMM_SL2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = imm_alu_op(opcode_i);
            end
            S_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = (op_class == CLS_R) ? REGDST_RD : REGDST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_RS;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (op_class == CLS_STORE) ? ALU_SW : ALU_LW;
            end
            S_MEM_READ: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEM_WRITE: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = SRCA_RS;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = (opcode_i == OP_BNE) ? ALU_BNE : ALU_BEQ;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (opcode_i == OP_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.alu_op    = ALU_J;
            end
            S_JAL_LINK: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.alu_op     = ALU_JAL;
            end
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_RS;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_TRAP:  ctrl.error = 1'b1;
            default: ctrl.error = 1'b1;
        endcase
        // Reset must silence FETCH's request immediately, not at the next edge.
        if (reset) begin
            ctrl = '0;
        end
    end

    assign mem_req_o       = ctrl.mem_req;
    assign mem_we_o        = ctrl.mem_we;
    assign iord_o          = ctrl.iord;
    assign ir_write_o      = ctrl.ir_write;
    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign branch_ne_o     = ctrl.branch_ne;
    assign pc_source_o     = ctrl.pc_source;
    assign reg_write_o     = ctrl.reg_write;
    assign reg_dst_o       = ctrl.reg_dst;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ctrl.alu_op;
    assign state_o         = state_q;
    assign error_o         = ctrl.error;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm: each instruction is expanded into
// its expected per-cycle control outputs and checked by an independent monitor.
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    localparam int unsigned TMO     = 3;
    localparam int unsigned N_INSTR = 500;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [3:0] state;
        logic       error;
    } obs_t;

    logic       clk;
    logic       reset;
    logic [5:0] opcode_i;
    logic       jump_register_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o;
    logic       branch_ne_o, reg_write_o, alu_src_a_o, error_o;
    logic [1:0] pc_source_o, reg_dst_o, mem_to_reg_o, alu_src_b_o;
    logic [3:0] alu_op_o, state_o;

    obs_t       act;
    obs_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [5:0] cur_op;
    logic       cur_jr;

    multicycle_control_fsm #(
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .opcode_i       (opcode_i),
        .jump_register_i(jump_register_i),
        .zero_i         (zero_i),
        .mem_ready_i    (mem_ready_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .iord_o         (iord_o),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .pc_write_cond_o(pc_write_cond_o),
        .branch_ne_o    (branch_ne_o),
        .pc_source_o    (pc_source_o),
        .reg_write_o    (reg_write_o),
        .reg_dst_o      (reg_dst_o),
        .mem_to_reg_o   (mem_to_reg_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .alu_op_o       (alu_op_o),
        .state_o        (state_o),
        .error_o        (error_o)
    );

    assign act = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o,
                  branch_ne_o, pc_source_o, reg_write_o, reg_dst_o, mem_to_reg_o,
                  alu_src_a_o, alu_src_b_o, alu_op_o, state_o, error_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares whatever the DUT shows mid-cycle against the oldest expectation.
    initial begin
        obs_t       e;
        logic [25:0] av, ev;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                av = act;
                ev = e;
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got %h (state %0d) expected %h (state %0d)",
                             $time, av, act.state, ev, e.state);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t idle(input logic [3:0] s);
        obs_t o;
        o       = '0;
        o.state = s;
        return o;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                          6'h0F, 6'h23, 6'h2B};
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] legal[11];
        logic [5:0] x;
        int         r;
        legal = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        r = $urandom_range(0, 99);
        if (r < 4) return 6'h3F;
        if (r < 8) begin
            x = 6'($urandom);
            while (is_legal(x)) x = 6'($urandom);
            return x;
        end
        return legal[$urandom_range(0, 10)];
    endfunction

    task automatic step(input logic rdy, input obs_t e);
        @(posedge clk);
        #1;
        reset           = 1'b0;
        opcode_i        = cur_op;
        jump_register_i = cur_jr;
        zero_i          = 1'($urandom);
        mem_ready_i     = rdy;
        exp_q.push_back(e);
    endtask

    // Reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset       = 1'b1;
        mem_ready_i = 1'($urandom);
        opcode_i    = 6'($urandom);
        exp_q.push_back(idle(S_FETCH));
    endtask

    task automatic trap_phase();
        obs_t e;
        e       = idle(S_TRAP);
        e.error = 1'b1;
        repeat ($urandom_range(1, 3)) step(1'($urandom), e);
        do_reset();
    endtask

    // status: 0 access completed, 1 timed out, 2 reset injected during the wait
    task automatic mem_phase(input obs_t base, input logic is_fetch, output int status);
        int unsigned waits;
        int          r;
        obs_t        e;
        r = $urandom_range(0, 99);
        if (r < 8)       waits = TMO;
        else if (r < 25) waits = TMO - 1;
        else             waits = $urandom_range(0, TMO - 1);
        for (int unsigned i = 0; i < waits; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
                status = 2;
                return;
            end
            step(1'b0, base);
        end
        if (waits == TMO) begin
            status = 1;
            return;
        end
        e = base;
        if (is_fetch) begin
            e.ir_write = 1'b1;
            e.pc_write = 1'b1;
        end
        step(1'b1, e);
        status = 0;
    endtask

    task automatic run_instr();
        obs_t e;
        int   st;
        cur_op = pick_op();
        cur_jr = (cur_op == 6'h00) ? ($urandom_range(0, 3) == 0) : 1'($urandom);

        e = idle(S_FETCH);
        e.mem_req   = 1'b1;
        e.alu_src_b = 2'd1;
        mem_phase(e, 1'b1, st);
        if (st == 1) begin trap_phase(); return; end
        if (st == 2) return;

        e = idle(S_DECODE);
        e.alu_src_b = 2'd3;
        step(1'($urandom), e);

        case (cur_op)
            6'h00: begin
                if (cur_jr) begin
                    e = idle(S_JR);
                    e.pc_write = 1'b1; e.pc_source = 2'd3; e.alu_op = 4'b1111;
                    step(1'($urandom), e);
                end else begin
                    e = idle(S_EXEC_R);
                    e.alu_src_a = 1'b1; e.alu_src_b = 2'd0; e.alu_op = 4'b1111;
                    step(1'($urandom), e);
                    e = idle(S_ALU_WB);
                    e.reg_write = 1'b1; e.reg_dst = 2'd1;
                    step(1'($urandom), e);
                end
            end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                e = idle(S_EXEC_I);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                case (cur_op)
                    6'h0C:   e.alu_op = 4'b0011;
                    6'h0D:   e.alu_op = 4'b0001;
                    6'h0F:   e.alu_op = 4'b0010;
                    default: e.alu_op = 4'b0000;
                endcase
                step(1'($urandom), e);
                e = idle(S_ALU_WB);
                e.reg_write = 1'b1; e.reg_dst = 2'd0;
                step(1'($urandom), e);
            end
            6'h23, 6'h2B: begin
                e = idle(S_MEM_ADDR);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                e.alu_op = (cur_op == 6'h23) ? 4'b0100 : 4'b0101;
                step(1'($urandom), e);
                if (cur_op == 6'h23) begin
                    e = idle(S_MEM_READ);
                    e.mem_req = 1'b1; e.iord = 1'b1;
                end else begin
                    e = idle(S_MEM_WRITE);
                    e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
                end
                mem_phase(e, 1'b0, st);
                if (st == 1) begin trap_phase(); return; end
                if (st == 2) return;
                if (cur_op == 6'h23) begin
                    e = idle(S_MEM_WB);
                    e.reg_write = 1'b1; e.reg_dst = 2'd0; e.mem_to_reg = 2'd1;
                    step(1'($urandom), e);
                end
            end
            6'h04, 6'h05: begin
                e = idle(S_BRANCH);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd0; e.pc_write_cond = 1'b1;
                e.pc_source = 2'd1;
                e.branch_ne = (cur_op == 6'h05);
                e.alu_op    = (cur_op == 6'h05) ? 4'b0111 : 4'b0110;
                step(1'($urandom), e);
            end
            6'h02: begin
                e = idle(S_JUMP);
                e.pc_write = 1'b1; e.pc_source = 2'd2; e.alu_op = 4'b1000;
                step(1'($urandom), e);
            end
            6'h03: begin
                e = idle(S_JAL_LINK);
                e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
                e.pc_write = 1'b1; e.pc_source = 2'd2; e.alu_op = 4'b1001;
                step(1'($urandom), e);
            end
            default: trap_phase();
        endcase
    endtask

    initial begin
        reset           = 1'b1;
        opcode_i        = '0;
        jump_register_i = 1'b0;
        zero_i          = 1'b0;
        mem_ready_i     = 1'b0;
        cur_op          = '0;
        cur_jr          = 1'b0;
        do_reset();
        for (int i = 0; i < N_INSTR; i++) run_instr();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
